execute_stage_mc: RTL and testbench



---
 rtl/execute_stage_mc.sv | 211 +++++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// Execute stage with multi-cycle shift/multiply support.
// The ALU, branch resolution and forwarding are evaluated combinationally
// from the held rr_* operands. A small latency FSM stretches shifts and
// multiplies by holding exec_stall until the configured number of extra
// cycles has elapsed. Results are then committed to the writeback
// registers, and the perf counters are updated.
module execute_stage_mc #(
  parameter int WIDTH     = 32,
  parameter int SHIFT_LAT = 0,
  parameter int MUL_LAT   = 2,
  parameter int CNT_W     = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             rr_valid,
  input  logic [WIDTH-1:0] rr_pc,
  input  logic [5:0]       rr_op,
  input  logic [7:0]       rr_altop,
  input  logic [3:0]       rr_rd,
  input  logic [WIDTH-1:0] rr_rs_val,
  input  logic [WIDTH-1:0] rr_rt_val,
  input  logic [WIDTH-1:0] rr_imm,
  input  logic [WIDTH-1:0] decode_pc,
  output logic             exec_stall,
  output logic             exec_flush,
  output logic [WIDTH-1:0] exec_br_pc,
  output logic             exec_ld_pc,
  output logic [3:0]       exec_of_reg,
  output logic             exec_of_valid,
  output logic [WIDTH-1:0] exec_of_val,
  output logic [3:0]       exec_rd,
  output logic [WIDTH-1:0] exec_rd_val,
  output logic             exec_halted,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int SH_W = $clog2(WIDTH);

  // Primary opcodes; 0 selects the extended opcode space.
  localparam logic [5:0] OP_EXT  = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_ANDI = 6'd2;
  localparam logic [5:0] OP_ORI  = 6'd3;
  localparam logic [5:0] OP_XORI = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_BLT  = 6'd6;
  localparam logic [5:0] OP_BLE  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;
  localparam logic [5:0] OP_JAL  = 6'd9;

  // Extended opcodes; 0 is the NOP encoding.
  localparam logic [7:0] EXTOP_EQ   = 8'd1;
  localparam logic [7:0] EXTOP_LT   = 8'd2;
  localparam logic [7:0] EXTOP_LE   = 8'd3;
  localparam logic [7:0] EXTOP_NE   = 8'd4;
  localparam logic [7:0] EXTOP_ADD  = 8'd5;
  localparam logic [7:0] EXTOP_SUB  = 8'd6;
  localparam logic [7:0] EXTOP_AND  = 8'd7;
  localparam logic [7:0] EXTOP_OR   = 8'd8;
  localparam logic [7:0] EXTOP_XOR  = 8'd9;
  localparam logic [7:0] EXTOP_NAND = 8'd10;
  localparam logic [7:0] EXTOP_NOR  = 8'd11;
  localparam logic [7:0] EXTOP_NXOR = 8'd12;
  localparam logic [7:0] EXTOP_RSHF = 8'd13;
  localparam logic [7:0] EXTOP_LSHF = 8'd14;
  localparam logic [7:0] EXTOP_MUL  = 8'd15;

  localparam logic [3:0] SHIFT_L = 4'(SHIFT_LAT);
  localparam logic [3:0] MUL_L   = 4'(MUL_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]  result;
  logic [3:0]        lat;
  logic              valid_op;
  logic              do_jump;
  logic              br_cond;
  logic              commit;
  logic              cmp_eq, cmp_lt;
  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic [SH_W-1:0]   sh_amt;

  assign rs_s     = $signed(rr_rs_val);
  assign rt_s     = $signed(rr_rt_val);
  assign cmp_eq   = (rr_rs_val == rr_rt_val);
  assign cmp_lt   = (rs_s < rt_s);
  assign sh_amt   = rr_rt_val[SH_W-1:0];
  assign valid_op = rr_valid && !(rr_op == OP_EXT && rr_altop == 8'd0);

  // ALU result and per-op extra latency.
  always_comb begin
    result = '0;
    lat    = 4'd0;
    case (rr_op)
      OP_EXT: begin
        case (rr_altop)
          EXTOP_EQ:   result = {{(WIDTH-1){1'b0}}, cmp_eq};
          EXTOP_LT:   result = {{(WIDTH-1){1'b0}}, cmp_lt};
          EXTOP_LE:   result = {{(WIDTH-1){1'b0}}, cmp_lt | cmp_eq};
          EXTOP_NE:   result = {{(WIDTH-1){1'b0}}, !cmp_eq};
          EXTOP_ADD:  result = rr_rs_val + rr_rt_val;
          EXTOP_SUB:  result = rr_rs_val - rr_rt_val;
          EXTOP_AND:  result = rr_rs_val & rr_rt_val;
          EXTOP_OR:   result = rr_rs_val | rr_rt_val;
          EXTOP_XOR:  result = rr_rs_val ^ rr_rt_val;
          EXTOP_NAND: result = ~(rr_rs_val & rr_rt_val);
          EXTOP_NOR:  result = ~(rr_rs_val | rr_rt_val);
          EXTOP_NXOR: result = ~(rr_rs_val ^ rr_rt_val);
          EXTOP_RSHF: begin
            result = $unsigned(rs_s >>> sh_amt);
            lat    = SHIFT_L;
          end
          EXTOP_LSHF: begin
            result = rr_rs_val << sh_amt;
            lat    = SHIFT_L;
          end
          EXTOP_MUL: begin
            result = rr_rs_val * rr_rt_val;
            lat    = MUL_L;
          end
          default:    result = '0;
        endcase
      end
      OP_ADDI: result = rr_rs_val + rr_imm;
      OP_ANDI: result = rr_rs_val & rr_imm;
      OP_ORI:  result = rr_rs_val | rr_imm;
      OP_XORI: result = rr_rs_val ^ rr_imm;
      OP_JAL:  result = rr_pc + WIDTH'(4);
      default: result = '0;
    endcase
  end

  // Branch condition, target and fetch redirect.
  always_comb begin
    br_cond = 1'b0;
    case (rr_op)
      OP_BEQ:  br_cond = cmp_eq;
      OP_BLT:  br_cond = cmp_lt;
      OP_BLE:  br_cond = cmp_lt | cmp_eq;
      OP_BNE:  br_cond = !cmp_eq;
      OP_JAL:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
    exec_br_pc = (rr_op == OP_JAL) ? (rr_imm + rr_rs_val) : rr_imm;
    do_jump    = rr_valid && !exec_halted && br_cond;
    exec_flush = do_jump;
    exec_ld_pc = do_jump && (decode_pc != exec_br_pc);
  end

  // Latency FSM: next state, delay counter, stall and commit strobe.
  // A jump onto its own PC is an idle loop and parks the stage in HALT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    exec_stall = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_op && lat != 4'd0) begin
          exec_stall = 1'b1;
          state_next = BUSY;
          cnt_next   = lat - 4'd1;
        end else begin
          commit = 1'b1;
          if (exec_ld_pc && rr_pc == exec_br_pc) state_next = HALT;
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) begin
          exec_stall = 1'b1;
          cnt_next   = cnt_reg - 4'd1;
        end else begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      HALT:    exec_stall = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  assign exec_halted   = (state_reg == HALT);
  assign exec_of_reg   = rr_rd;
  assign exec_of_valid = rr_valid && !exec_stall;
  assign exec_of_val   = result;

  // State, writeback registers and perf counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      exec_rd     <= 4'd0;
      exec_rd_val <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (commit) begin
        exec_rd     <= valid_op ? rr_rd : 4'd0;
        exec_rd_val <= valid_op ? result : '0;
        if (valid_op) inst_count <= inst_count + CNT_W'(1);
      end
      if (!exec_halted) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: scoreboard of expected
// writebacks filled by the stimulus, drained by a monitor on exec_of_valid.
module tb_execute_stage_mc;

  localparam int MUL_LAT_A   = 2;
  localparam int SHIFT_LAT_A = 0;

  localparam logic [5:0] OP_EXT = 0, OP_ADDI = 1, OP_ANDI = 2, OP_ORI = 3, OP_XORI = 4,
                         OP_BEQ = 5, OP_BLT = 6, OP_BLE = 7, OP_BNE = 8, OP_JAL = 9;
  localparam logic [7:0] X_EQ = 1, X_LT = 2, X_LE = 3, X_NE = 4, X_ADD = 5, X_SUB = 6,
                         X_AND = 7, X_OR = 8, X_XOR = 9, X_NAND = 10, X_NOR = 11,
                         X_NXOR = 12, X_RSHF = 13, X_LSHF = 14, X_MUL = 15;

  logic        clk = 0;
  logic        i_reset;
  always #5 clk = ~clk;

  // DUT A: 32-bit, SHIFT_LAT=0, MUL_LAT=2
  logic        rr_valid;
  logic [31:0] rr_pc, rr_rs_val, rr_rt_val, rr_imm, decode_pc;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd;
  logic        exec_stall, exec_flush, exec_ld_pc, exec_of_valid, exec_halted;
  logic [31:0] exec_br_pc, exec_of_val, exec_rd_val;
  logic [3:0]  exec_of_reg, exec_rd;
  logic [63:0] inst_count, cycle_count;

  execute_stage_mc #(.WIDTH(32), .SHIFT_LAT(SHIFT_LAT_A), .MUL_LAT(MUL_LAT_A), .CNT_W(64)) dut (
    .i_clk(clk), .i_reset(i_reset), .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_op(rr_op),
    .rr_altop(rr_altop), .rr_rd(rr_rd), .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val),
    .rr_imm(rr_imm), .decode_pc(decode_pc), .exec_stall(exec_stall), .exec_flush(exec_flush),
    .exec_br_pc(exec_br_pc), .exec_ld_pc(exec_ld_pc), .exec_of_reg(exec_of_reg),
    .exec_of_valid(exec_of_valid), .exec_of_val(exec_of_val), .exec_rd(exec_rd),
    .exec_rd_val(exec_rd_val), .exec_halted(exec_halted), .inst_count(inst_count),
    .cycle_count(cycle_count));

  // DUT B: 16-bit, SHIFT_LAT=3, MUL_LAT=0
  logic        b_valid;
  logic [15:0] b_pc, b_rs, b_rt, b_imm, b_dpc;
  logic [5:0]  b_op;
  logic [7:0]  b_alt;
  logic [3:0]  b_rd_in;
  logic        b_stall, b_flush, b_ld_pc, b_of_valid, b_halted;
  logic [15:0] b_br_pc, b_of_val, b_rd_val;
  logic [3:0]  b_of_reg, b_rd;
  logic [31:0] b_inst_count, b_cycle_count;

  execute_stage_mc #(.WIDTH(16), .SHIFT_LAT(3), .MUL_LAT(0), .CNT_W(32)) dut_b (
    .i_clk(clk), .i_reset(i_reset), .rr_valid(b_valid), .rr_pc(b_pc), .rr_op(b_op),
    .rr_altop(b_alt), .rr_rd(b_rd_in), .rr_rs_val(b_rs), .rr_rt_val(b_rt),
    .rr_imm(b_imm), .decode_pc(b_dpc), .exec_stall(b_stall), .exec_flush(b_flush),
    .exec_br_pc(b_br_pc), .exec_ld_pc(b_ld_pc), .exec_of_reg(b_of_reg),
    .exec_of_valid(b_of_valid), .exec_of_val(b_of_val), .exec_rd(b_rd),
    .exec_rd_val(b_rd_val), .exec_halted(b_halted), .inst_count(b_inst_count),
    .cycle_count(b_cycle_count));

  typedef struct {
    logic [3:0]  of_reg;
    logic [31:0] of_val;
    bit          chk_val;
    logic [3:0]  rd;
    logic [31:0] rd_val;
    logic [63:0] inst;
  } sb_t;

  sb_t         sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] model_inst = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic.
  function automatic void model(input logic [5:0] op, input logic [7:0] alt,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] pc,
                                output logic [31:0] res, output int lat,
                                output bit jump, output logic [31:0] br);
    longint          sa, sb, q, d;
    longint unsigned ua, ub;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    res = 0; lat = 0; jump = 0; br = imm;
    if (op == OP_EXT) begin
      case (alt)
        X_EQ:   res = (sa == sb) ? 1 : 0;
        X_LT:   res = (sa < sb) ? 1 : 0;
        X_LE:   res = (sa <= sb) ? 1 : 0;
        X_NE:   res = (sa != sb) ? 1 : 0;
        X_ADD:  res = 32'(ua + ub);
        X_SUB:  res = 32'(ua + 64'h1_0000_0000 - ub);
        X_AND:  res = a & b;
        X_OR:   res = a | b;
        X_XOR:  res = a ^ b;
        X_NAND: res = ~(a & b);
        X_NOR:  res = ~(a | b);
        X_NXOR: res = ~(a ^ b);
        X_RSHF: begin
          d = longint'(1) << sh;
          q = sa / d;
          if (sa < 0 && (sa % d) != 0) q = q - 1;
          res = 32'(q);
          lat = SHIFT_LAT_A;
        end
        X_LSHF: begin
          res = 32'(ua * (longint'(1) << sh));
          lat = SHIFT_LAT_A;
        end
        X_MUL: begin
          res = 32'(ua * ub);
          lat = MUL_LAT_A;
        end
        default: res = 0;
      endcase
    end else begin
      case (op)
        OP_ADDI: res = 32'(ua + longint'(imm));
        OP_ANDI: res = a & imm;
        OP_ORI:  res = a | imm;
        OP_XORI: res = a ^ imm;
        OP_BEQ:  jump = (sa == sb);
        OP_BLT:  jump = (sa < sb);
        OP_BLE:  jump = (sa <= sb);
        OP_BNE:  jump = (sa != sb);
        OP_JAL: begin
          jump = 1;
          res  = 32'(longint'(pc) + 4);
          br   = 32'(longint'(imm) + ua);
        end
        default: res = 0;
      endcase
    end
  endfunction

  // Drive one instruction (starting just after a rising edge), hold it for
  // its whole latency, check stall length and branch outputs.
  task automatic issue(input bit v, input logic [5:0] op, input logic [7:0] alt,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] dpc);
    logic [31:0] res, br;
    int          lat, stalls;
    bit          jump, nop, ldpc;
    sb_t         e;
    rr_valid = v; rr_op = op; rr_altop = alt; rr_rd = rd;
    rr_rs_val = a; rr_rt_val = b; rr_imm = imm; rr_pc = pc; decode_pc = dpc;
    model(op, alt, a, b, imm, pc, res, lat, jump, br);
    nop  = !v || (op == OP_EXT && alt == 8'd0);
    if (nop) lat = 0;
    jump = jump && v;
    ldpc = jump && (dpc != br);
    if (v) begin
      if (!nop) model_inst++;
      e.of_reg = rd; e.of_val = res; e.chk_val = !nop;
      e.rd = nop ? 4'd0 : rd; e.rd_val = nop ? 32'd0 : res; e.inst = model_inst;
      sb_q.push_back(e);
    end
    $display("txn v=%0d op=%0d alt=%0d rd=%0d a=%h b=%h imm=%h pc=%h exp=%h lat=%0d jump=%0d",
             v, op, alt, rd, a, b, imm, pc, res, lat, jump);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!exec_stall) break;
      stalls++;
      if (stalls > 40) break;
      @(posedge clk); #1;
    end
    chk("stall_cycles", 64'(stalls), 64'(lat));
    chk("flush", 64'(exec_flush), 64'(jump));
    chk("ld_pc", 64'(exec_ld_pc), 64'(ldpc));
    if (jump) chk("br_pc", 64'(exec_br_pc), 64'(br));
    @(posedge clk); #1;
    rr_valid = 0;
  endtask

  // Monitor: each forwarded-final result pops one expectation; the
  // registered writeback and retire count are checked after the edge.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!i_reset && exec_of_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: got of_valid with of_reg=%0d required none", exec_of_reg);
        end else begin
          e = sb_q.pop_front();
          chk("of_reg", 64'(exec_of_reg), 64'(e.of_reg));
          if (e.chk_val) chk("of_val", 64'(exec_of_val), 64'(e.of_val));
          @(posedge clk); #1;
          chk("exec_rd", 64'(exec_rd), 64'(e.rd));
          chk("exec_rd_val", 64'(exec_rd_val), 64'(e.rd_val));
          chk("inst_count", inst_count, e.inst);
        end
      end
    end
  end

  initial begin
    logic [63:0] cc;
    logic [31:0] a, b, imm, pc, dpc, br;
    logic [5:0]  op;
    logic [7:0]  alt;
    int          kind, stalls;
    bit          v;

    i_reset = 1; rr_valid = 0; rr_pc = 0; rr_op = 0; rr_altop = 0; rr_rd = 0;
    rr_rs_val = 0; rr_rt_val = 0; rr_imm = 0; decode_pc = 0;
    b_valid = 0; b_pc = 0; b_op = 0; b_alt = 0; b_rd_in = 0; b_rs = 0; b_rt = 0;
    b_imm = 0; b_dpc = 0;
    repeat (3) @(posedge clk);
    #1 i_reset = 0;
    @(negedge clk);
    chk("rst_exec_rd", 64'(exec_rd), 0);
    chk("rst_exec_rd_val", 64'(exec_rd_val), 0);
    chk("rst_halted", 64'(exec_halted), 0);
    chk("rst_stall", 64'(exec_stall), 0);
    chk("rst_inst_count", inst_count, 0);
    chk("rst_cycle_count", cycle_count, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cycle_count_5", cycle_count, 5);
    @(posedge clk); #1;

    // Directed cases
    issue(1, OP_EXT, X_ADD, 4'd3, 32'd7, 32'd5, 0, 32'h0, 32'h4);
    issue(1, OP_EXT, X_MUL, 4'd4, 32'd6, 32'd7, 0, 32'h4, 32'h8);
    issue(1, OP_EXT, X_RSHF, 4'd5, 32'h8000_0000, 32'd4, 0, 32'h8, 32'hC);
    issue(1, OP_EXT, X_LSHF, 4'd6, 32'h0000_0003, 32'd33, 0, 32'hC, 32'h10);
    issue(1, OP_BEQ, 8'd0, 4'd0, 32'd5, 32'd5, 32'h40, 32'h10, 32'h40);
    issue(1, OP_BEQ, 8'd0, 4'd0, 32'd5, 32'd5, 32'h40, 32'h10, 32'h44);
    issue(1, OP_EXT, 8'd0, 4'd7, 32'd1, 32'd2, 0, 32'h14, 32'h18);
    issue(1, OP_EXT, 8'd99, 4'd8, 32'd1, 32'd2, 0, 32'h18, 32'h1C);
    issue(0, OP_EXT, X_ADD, 4'd9, 32'd1, 32'd2, 0, 32'h1C, 32'h20);

    // Randomized traffic; PCs end in 2'b10 and targets in 2'b00 so no halt
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      imm  = $urandom & 32'hFFFF_FFFC;
      pc   = ($urandom & 32'hFFFF_FFFC) | 32'h2;
      v    = ($urandom_range(0, 9) != 0);
      op   = OP_EXT; alt = 8'($urandom_range(1, 15));
      case (kind)
        0: alt = X_MUL;
        1: alt = ($urandom_range(0, 1) == 1) ? X_RSHF : X_LSHF;
        2: op = 6'($urandom_range(1, 4));
        3: op = 6'($urandom_range(5, 8));
        4: begin op = OP_JAL; a = a & 32'hFFFF_FFFC; end
        5: alt = 8'($urandom_range(0, 20));
        default: ;
      endcase
      br  = (op == OP_JAL) ? imm + a : imm;
      dpc = ($urandom_range(0, 1) == 1) ? br : $urandom;
      issue(v, op, alt, 4'($urandom), a, b, imm, pc, dpc);
    end

    // Self-loop JAL infers a halt
    issue(1, OP_JAL, 8'd0, 4'd1, 32'd0, 32'd0, 32'h100, 32'h100, 32'h104);
    @(negedge clk);
    chk("halted", 64'(exec_halted), 1);
    chk("halt_stall", 64'(exec_stall), 1);
    cc = cycle_count;
    rr_valid = 1; rr_op = OP_BEQ; rr_altop = 0; rr_rs_val = 1; rr_rt_val = 1;
    rr_imm = 32'h200; rr_pc = 32'h300; decode_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_cycle_freeze", cycle_count, cc);
    chk("halt_no_flush", 64'(exec_flush), 0);
    chk("halt_rd_val_kept", 64'(exec_rd_val), 32'h104);
    chk("sb_drained", 64'(sb_q.size()), 0);

    // Reset clears halt
    @(posedge clk); #1;
    rr_valid = 0; i_reset = 1;
    @(posedge clk); #1;
    i_reset = 0; sb_q.delete(); model_inst = 0;
    @(negedge clk);
    chk("unhalt", 64'(exec_halted), 0);

    // Reset during a multiply abandons it
    @(posedge clk); #1;
    rr_valid = 1; rr_op = OP_EXT; rr_altop = X_MUL; rr_rd = 4'd2;
    rr_rs_val = 32'd9; rr_rt_val = 32'd9;
    @(posedge clk); #1;
    chk("busy_stall", 64'(exec_stall), 1);
    i_reset = 1; rr_valid = 0;
    @(posedge clk); #1;
    i_reset = 0;
    @(negedge clk);
    chk("midmul_stall", 64'(exec_stall), 0);
    chk("midmul_rd", 64'(exec_rd), 0);
    chk("midmul_inst", inst_count, 0);
    chk("midmul_cycle", cycle_count, 0);

    // 16-bit instance: wraparound, shift latency 3, single-cycle multiply
    @(posedge clk); #1;
    b_valid = 1; b_op = OP_EXT; b_alt = X_ADD; b_rd_in = 4'd2; b_rs = 16'hFFFF; b_rt = 16'h1;
    $display("txn b ADD ffff+1");
    @(negedge clk);
    chk("b_add_stall", 64'(b_stall), 0);
    @(posedge clk); #1;
    chk("b_add_val", 64'(b_rd_val), 0);
    chk("b_add_rd", 64'(b_rd), 2);
    chk("b_inst_1", 64'(b_inst_count), 1);
    b_alt = X_RSHF; b_rd_in = 4'd3; b_rs = 16'h8000; b_rt = 16'd4;
    $display("txn b RSHF 8000>>>4");
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!b_stall) break;
      stalls++;
      if (stalls > 40) break;
      @(posedge clk); #1;
    end
    chk("b_shift_stalls", 64'(stalls), 3);
    @(posedge clk); #1;
    chk("b_shift_val", 64'(b_rd_val), 16'hF800);
    chk("b_inst_2", 64'(b_inst_count), 2);
    b_alt = X_MUL; b_rd_in = 4'd4; b_rs = 16'd300; b_rt = 16'd300;
    $display("txn b MUL 300*300");
    @(negedge clk);
    chk("b_mul_stall", 64'(b_stall), 0);
    @(posedge clk); #1;
    chk("b_mul_val", 64'(b_rd_val), 16'h5F90);
    b_valid = 0;
    @(negedge clk);
    chk("sb_final_empty", 64'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
